insert0_sched: RTL and testbench



---
 rtl/insert0_sched.sv | 225 ++++++++++++++++++++++
 tb/tb_insert0_sched.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/insert0_sched.sv
// Round-robin scheduler sharing one zero-insertion datapath among N_CH frame sources.
// Optional abort input and ABORT state are enabled by defining INSERT0_SCHED_ABORT_EN.
module insert0_sched #(
  parameter int N_CH      = 4,
  parameter int CW        = 2,
  parameter int MAX_LEN   = 511,
  parameter int BYTE_CYC  = 8,
  parameter int FEED_OFS  = 2,
  parameter int DRAIN_CYC = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   req,
  input  logic [N_CH*10-1:0] len_i,
`ifdef INSERT0_SCHED_ABORT_EN
  input  logic              abort,
`endif
  output logic [N_CH-1:0]   gnt,
  output logic [N_CH-1:0]   done,
  output logic              err,
  output logic              inr,
  output logic              trastart_flag,
  output logic [9:0]        db,
  output logic              buf_rden,
  output logic [CW-1:0]     buf_ch,
  output logic [8:0]        buf_raddr,
  output logic              busy
);

  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLR    = 3'd1,
    S_REJECT = 3'd2,
    S_START  = 3'd3,
    S_FEED   = 3'd4,
    S_DRAIN  = 3'd5,
`ifdef INSERT0_SCHED_ABORT_EN
    S_DONE   = 3'd6,
    S_ABORT  = 3'd7
`else
    S_DONE   = 3'd6
`endif
  } state_t;

  state_t            state_r, state_c_s, state_n_s;
  logic [CW-1:0]     ch_r, ch_n_s, rr_r, rr_n_s, win_s, idx_s;
  logic [9:0]        len_r, len_n_s;
  logic [9:0]        len_a_s [N_CH];
  logic              bad_r, bad_n_s, found_s;
  logic [CNT_W-1:0]  cnt_r, cnt_n_s;
  logic [8:0]        addr_r, addr_n_s;
  logic [N_CH-1:0]   gnt_r, done_r, gnt_s, done_s, onehot_s;
  logic              err_r, inr_r, tra_r, rden_r, busy_r;
  logic              err_s, inr_s, tra_s, rden_s;
  logic [9:0]        db_r, db_s;

`ifdef INSERT0_SCHED_ABORT_EN
  logic abort_s;
  assign abort_s   = abort && (state_r == S_START || state_r == S_FEED || state_r == S_DRAIN);
  assign state_n_s = abort_s ? S_ABORT : state_c_s;
`else
  assign state_n_s = state_c_s;
`endif

  // Unpack lengths and pick the first requester at or after the round-robin pointer
  always_comb begin
    found_s = 1'b0;
    win_s   = '0;
    idx_s   = '0;
    for (int k = 0; k < N_CH; k++) begin
      len_a_s[k] = len_i[10*k +: 10];
    end
    for (int i = 0; i < N_CH; i++) begin
      idx_s   = CW'((int'(rr_r) + i) % N_CH);
      win_s   = (!found_s && req[idx_s]) ? idx_s : win_s;
      found_s = found_s | req[idx_s];
    end
  end

  // Next-state, counter and address sequencing
  always_comb begin
    state_c_s = state_r;
    ch_n_s    = ch_r;
    rr_n_s    = rr_r;
    len_n_s   = len_r;
    bad_n_s   = bad_r;
    cnt_n_s   = cnt_r;
    addr_n_s  = addr_r;
    case (state_r)
      S_IDLE: begin
        if (found_s) begin
          state_c_s = S_CLR;
          ch_n_s    = win_s;
          rr_n_s    = (win_s == CW'(N_CH - 1)) ? '0 : win_s + CW'(1);
          len_n_s   = len_a_s[win_s];
          bad_n_s   = (len_a_s[win_s] == 10'd0) || (len_a_s[win_s] > 10'(MAX_LEN));
          addr_n_s  = 9'd0;
        end else begin
          state_c_s = S_IDLE;
        end
      end
      S_CLR:   state_c_s = bad_r ? S_REJECT : S_START;
      S_START: begin
        state_c_s = S_FEED;
        cnt_n_s   = CNT_W'(FEED_OFS - 1);
      end
      S_FEED: begin
        if (cnt_r == '0) begin
          if ({1'b0, addr_r} == len_r - 10'd1) begin
            state_c_s = S_DRAIN;
            cnt_n_s   = CNT_W'(DRAIN_CYC - 1);
          end else begin
            addr_n_s = addr_r + 9'd1;
            cnt_n_s  = CNT_W'(BYTE_CYC - 1);
          end
        end else begin
          cnt_n_s = cnt_r - CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_r == '0) begin
          state_c_s = S_DONE;
        end else begin
          cnt_n_s = cnt_r - CNT_W'(1);
        end
      end
      S_REJECT, S_DONE: state_c_s = S_IDLE;
      default:          state_c_s = S_IDLE;
    endcase
  end

  // Output values for the state being entered, so every output comes straight from a flop
  always_comb begin
    onehot_s = {{(N_CH-1){1'b0}}, 1'b1} << ch_n_s;
    gnt_s    = '0;
    done_s   = '0;
    err_s    = 1'b0;
    inr_s    = 1'b0;
    tra_s    = 1'b0;
    db_s     = 10'd0;
    rden_s   = 1'b0;
    case (state_n_s)
      S_CLR: begin
        gnt_s = onehot_s;
        inr_s = 1'b1;
        db_s  = len_n_s;
      end
      S_START, S_DRAIN: begin
        gnt_s = onehot_s;
        tra_s = 1'b1;
        db_s  = len_n_s;
      end
      S_FEED: begin
        gnt_s  = onehot_s;
        tra_s  = 1'b1;
        db_s   = len_n_s;
        rden_s = (cnt_n_s == '0);
      end
      S_REJECT: begin
        done_s = onehot_s;
        err_s  = 1'b1;
      end
      S_DONE: done_s = onehot_s;
`ifdef INSERT0_SCHED_ABORT_EN
      S_ABORT: begin
        inr_s  = 1'b1;
        done_s = onehot_s;
        err_s  = 1'b1;
      end
`endif
      default: db_s = 10'd0;
    endcase
  end

  // State and registered outputs; reset discards any frame in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
      ch_r    <= '0;
      rr_r    <= '0;
      len_r   <= 10'd0;
      bad_r   <= 1'b0;
      cnt_r   <= '0;
      addr_r  <= 9'd0;
      gnt_r   <= '0;
      done_r  <= '0;
      err_r   <= 1'b0;
      inr_r   <= 1'b0;
      tra_r   <= 1'b0;
      db_r    <= 10'd0;
      rden_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_n_s;
      ch_r    <= ch_n_s;
      rr_r    <= rr_n_s;
      len_r   <= len_n_s;
      bad_r   <= bad_n_s;
      cnt_r   <= cnt_n_s;
      addr_r  <= addr_n_s;
      gnt_r   <= gnt_s;
      done_r  <= done_s;
      err_r   <= err_s;
      inr_r   <= inr_s;
      tra_r   <= tra_s;
      db_r    <= db_s;
      rden_r  <= rden_s;
      busy_r  <= (state_n_s != S_IDLE);
    end
  end

  assign gnt           = gnt_r;
  assign done          = done_r;
  assign err           = err_r;
  assign inr           = inr_r;
  assign trastart_flag = tra_r;
  assign db            = db_r;
  assign buf_rden      = rden_r;
  assign buf_ch        = ch_r;
  assign buf_raddr     = addr_r;
  assign busy          = busy_r;

endmodule

// File: tb/tb_insert0_sched.sv
// Directed testbench for insert0_sched (4 channels); covers abort when INSERT0_SCHED_ABORT_EN is defined.
module tb_insert0_sched;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [39:0] len_i;
`ifdef INSERT0_SCHED_ABORT_EN
  logic        abort;
`endif
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        err;
  logic        inr;
  logic        trastart_flag;
  logic [9:0]  db;
  logic        buf_rden;
  logic [1:0]  buf_ch;
  logic [8:0]  buf_raddr;
  logic        busy;

  int checks;
  int failures;

  insert0_sched dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .len_i         (len_i),
`ifdef INSERT0_SCHED_ABORT_EN
    .abort         (abort),
`endif
    .gnt           (gnt),
    .done          (done),
    .err           (err),
    .inr           (inr),
    .trastart_flag (trastart_flag),
    .db            (db),
    .buf_rden      (buf_rden),
    .buf_ch        (buf_ch),
    .buf_raddr     (buf_raddr),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst   = 1'b1;
    req   = 4'b0000;
    len_i = 40'd0;
`ifdef INSERT0_SCHED_ABORT_EN
    abort = 1'b0;
`endif
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if ({gnt, done, err, inr, trastart_flag, db, buf_rden, buf_ch, buf_raddr, busy} !== 33'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {gnt, done, err, inr, trastart_flag, db, buf_rden, buf_ch, buf_raddr, busy});
    end
    tick();
    checks++;
    if (busy !== 1'b0 || gnt !== 4'b0000) begin
      failures++;
      $display("FAIL reset_idle busy=%b gnt=%b exp busy=0 gnt=0000", busy, gnt);
    end
  endtask

  task automatic test_single;
    logic exp_rden;
    do_reset();
    len_i[9:0] = 10'd3;
    req = 4'b0001;
    tick();
    checks++;
    if (gnt !== 4'b0001 || inr !== 1'b1 || db !== 10'd3 || trastart_flag !== 1'b0) begin
      failures++;
      $display("FAIL single_clr gnt=%b inr=%b db=%0d tra=%b exp 0001 1 3 0", gnt, inr, db, trastart_flag);
    end
    tick();
    checks++;
    if (trastart_flag !== 1'b1 || inr !== 1'b0 || buf_rden !== 1'b0) begin
      failures++;
      $display("FAIL single_start tra=%b inr=%b rden=%b exp 1 0 0", trastart_flag, inr, buf_rden);
    end
    for (int t = 1; t <= 43; t++) begin
      tick();
      exp_rden = (t == 2) || (t == 10) || (t == 18);
      checks++;
      if (buf_rden !== exp_rden) begin
        failures++;
        $display("FAIL single_rden t=%0d got=%b exp=%b", t, buf_rden, exp_rden);
      end
      if (exp_rden) begin
        checks++;
        if (buf_raddr !== 9'((t - 2) / 8)) begin
          failures++;
          $display("FAIL single_raddr t=%0d got=%0d exp=%0d", t, buf_raddr, (t - 2) / 8);
        end
      end
      checks++;
      if (done !== ((t == 43) ? 4'b0001 : 4'b0000) || trastart_flag !== (t < 43)) begin
        failures++;
        $display("FAIL single_done t=%0d done=%b tra=%b", t, done, trastart_flag);
      end
      checks++;
      if (db !== ((t < 43) ? 10'd3 : 10'd0)) begin
        failures++;
        $display("FAIL single_db t=%0d got=%0d", t, db);
      end
      if (t == 43) begin
        checks++;
        if (err !== 1'b0 || gnt !== 4'b0000) begin
          failures++;
          $display("FAIL single_done_err err=%b gnt=%b exp 0 0000", err, gnt);
        end
      end
    end
    req = 4'b0000;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 4'b0000) begin
      failures++;
      $display("FAIL single_idle busy=%b done=%b exp 0 0000", busy, done);
    end
  endtask

  task automatic test_round_robin;
    logic [3:0] gexp [5];
    logic [3:0] prev_gnt;
    logic       prev_tra;
    logic       seen_high;
    int         ng;
    int         low_run;
    gexp[0] = 4'b0001; gexp[1] = 4'b0010; gexp[2] = 4'b0100; gexp[3] = 4'b1000; gexp[4] = 4'b0001;
    do_reset();
    len_i = {10'd1, 10'd1, 10'd1, 10'd1};
    req = 4'b1111;
    ng = 0; low_run = 0; prev_gnt = 4'b0000; prev_tra = 1'b0; seen_high = 1'b0;
    for (int c = 0; c < 400 && ng < 5; c++) begin
      tick();
      if (done !== 4'b0000 && ng > 0) begin
        checks++;
        if (done !== gexp[ng-1] || err !== 1'b0) begin
          failures++;
          $display("FAIL rr_done got=%b err=%b exp=%b 0", done, err, gexp[ng-1]);
        end
      end
      if (gnt !== 4'b0000 && prev_gnt === 4'b0000) begin
        checks++;
        if (gnt !== gexp[ng]) begin
          failures++;
          $display("FAIL rr_order idx=%0d got=%b exp=%b", ng, gnt, gexp[ng]);
        end
        ng++;
      end
      if (trastart_flag && !prev_tra && seen_high) begin
        checks++;
        if (low_run < 2) begin
          failures++;
          $display("FAIL rr_gap low_cycles=%0d exp>=2", low_run);
        end
      end
      if (trastart_flag) begin
        seen_high = 1'b1;
        low_run = 0;
      end else begin
        low_run++;
      end
      prev_gnt = gnt;
      prev_tra = trastart_flag;
    end
    checks++;
    if (ng != 5) begin
      failures++;
      $display("FAIL rr_timeout grants=%0d exp=5", ng);
    end
    req = 4'b0000;
  endtask

  task automatic test_reject_zero;
    do_reset();
    len_i[29:20] = 10'd0;
    len_i[39:30] = 10'd1;
    req = 4'b0100;
    tick();
    checks++;
    if (gnt !== 4'b0100 || inr !== 1'b1 || trastart_flag !== 1'b0 || buf_ch !== 2'd2) begin
      failures++;
      $display("FAIL rej0_clr gnt=%b inr=%b tra=%b ch=%0d exp 0100 1 0 2", gnt, inr, trastart_flag, buf_ch);
    end
    tick();
    checks++;
    if (done !== 4'b0100 || err !== 1'b1 || gnt !== 4'b0000 || inr !== 1'b0 || trastart_flag !== 1'b0 || buf_rden !== 1'b0) begin
      failures++;
      $display("FAIL rej0_reject done=%b err=%b gnt=%b inr=%b tra=%b rden=%b exp 0100 1 0000 0 0 0",
               done, err, gnt, inr, trastart_flag, buf_rden);
    end
    req = 4'b0000;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 4'b0000 || err !== 1'b0) begin
      failures++;
      $display("FAIL rej0_idle busy=%b done=%b err=%b exp 0 0000 0", busy, done, err);
    end
    req = 4'b1001;
    tick();
    checks++;
    if (gnt !== 4'b1000) begin
      failures++;
      $display("FAIL rej0_next_rr got=%b exp=1000", gnt);
    end
    req = 4'b0000;
  endtask

  task automatic test_len_bounds;
    int  nstrobe;
    int  last_cyc;
    int  done_cyc;
    logic [8:0] last_addr;
    do_reset();
    len_i[19:10] = 10'd512;
    req = 4'b0010;
    tick();
    tick();
    checks++;
    if (done !== 4'b0010 || err !== 1'b1 || trastart_flag !== 1'b0) begin
      failures++;
      $display("FAIL len512_reject done=%b err=%b tra=%b exp 0010 1 0", done, err, trastart_flag);
    end
    len_i[19:10] = 10'd511;
    tick();
    tick();
    checks++;
    if (gnt !== 4'b0010 || db !== 10'd511) begin
      failures++;
      $display("FAIL len511_grant gnt=%b db=%0d exp 0010 511", gnt, db);
    end
    nstrobe = 0; last_cyc = 0; done_cyc = -1; last_addr = 9'd0;
    for (int c = 0; c < 4400 && done_cyc < 0; c++) begin
      tick();
      if (buf_rden) begin
        checks++;
        if (buf_raddr !== 9'(nstrobe)) begin
          failures++;
          $display("FAIL len511_addr n=%0d got=%0d exp=%0d", nstrobe, buf_raddr, nstrobe);
        end
        nstrobe++;
        last_cyc = c;
        last_addr = buf_raddr;
      end
      if (done !== 4'b0000) begin
        done_cyc = c;
        checks++;
        if (done !== 4'b0010 || err !== 1'b0) begin
          failures++;
          $display("FAIL len511_done done=%b err=%b exp 0010 0", done, err);
        end
      end
    end
    checks++;
    if (done_cyc < 0) begin
      failures++;
      $display("FAIL len511_timeout got=no_done exp=done");
    end
    checks++;
    if (nstrobe != 511 || last_addr !== 9'd510) begin
      failures++;
      $display("FAIL len511_count strobes=%0d last=%0d exp 511 510", nstrobe, last_addr);
    end
    checks++;
    if (done_cyc - last_cyc != 25) begin
      failures++;
      $display("FAIL len511_drain gap=%0d exp=25", done_cyc - last_cyc);
    end
    req = 4'b0000;
  endtask

  task automatic test_reset_mid;
    do_reset();
    len_i[29:20] = 10'd5;
    req = 4'b0100;
    for (int i = 0; i < 14; i++) tick();
    checks++;
    if (trastart_flag !== 1'b1 || gnt !== 4'b0100) begin
      failures++;
      $display("FAIL rstmid_pre tra=%b gnt=%b exp 1 0100", trastart_flag, gnt);
    end
    req = 4'b1110;
    rst = 1'b1;
    #1;
    checks++;
    if ({gnt, done, err, inr, trastart_flag, db, buf_rden, buf_ch, buf_raddr, busy} !== 33'd0) begin
      failures++;
      $display("FAIL rstmid_outputs got=%h exp=0", {gnt, done, err, inr, trastart_flag, db, buf_rden, buf_ch, buf_raddr, busy});
    end
    tick();
    checks++;
    if (done !== 4'b0000) begin
      failures++;
      $display("FAIL rstmid_nodone got=%b exp=0000", done);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (gnt !== 4'b0010 || done !== 4'b0000) begin
      failures++;
      $display("FAIL rstmid_regrant gnt=%b done=%b exp 0010 0000", gnt, done);
    end
    req = 4'b0000;
  endtask

`ifdef INSERT0_SCHED_ABORT_EN
  task automatic test_abort;
    int nstrobe;
    do_reset();
    len_i[9:0]   = 10'd4;
    len_i[19:10] = 10'd1;
    req = 4'b0011;
    nstrobe = 0;
    for (int c = 0; c < 60 && nstrobe < 2; c++) begin
      tick();
      if (buf_rden) nstrobe++;
    end
    checks++;
    if (nstrobe != 2) begin
      failures++;
      $display("FAIL abort_timeout strobes=%0d exp=2", nstrobe);
    end
    abort = 1'b1;
    tick();
    checks++;
    if (inr !== 1'b1 || done !== 4'b0001 || err !== 1'b1 || gnt !== 4'b0000 || trastart_flag !== 1'b0 || buf_rden !== 1'b0) begin
      failures++;
      $display("FAIL abort_state inr=%b done=%b err=%b gnt=%b tra=%b rden=%b exp 1 0001 1 0000 0 0",
               inr, done, err, gnt, trastart_flag, buf_rden);
    end
    abort = 1'b0;
    req = 4'b0010;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 4'b0000) begin
      failures++;
      $display("FAIL abort_idle busy=%b done=%b exp 0 0000", busy, done);
    end
    tick();
    checks++;
    if (gnt !== 4'b0010) begin
      failures++;
      $display("FAIL abort_next got=%b exp=0010", gnt);
    end
    req = 4'b0000;
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    req = 4'b0000;
    len_i = 40'd0;
`ifdef INSERT0_SCHED_ABORT_EN
    abort = 1'b0;
`endif
    test_reset();
    test_single();
    test_round_robin();
    test_reject_zero();
    test_len_bounds();
    test_reset_mid();
`ifdef INSERT0_SCHED_ABORT_EN
    test_abort();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
